// File: rtl/pll_clk_en_sequencer.sv
// Lock-qualified reset sequencer and multi-channel fractional clock-enable generator.
// The PLL lock is synchronised and must stay high for STABLE_CYCLES before a
// RST_HOLD-cycle reset hold. After that, each channel's phase accumulator emits a
// one-cycle enable on every carry out of its ACC_W-bit accumulator.
module pll_clk_en_sequencer #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned ACC_W         = 24,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned RST_HOLD      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      lock_in,
    input  logic [N_CH*(ACC_W+1)-1:0] incr,
    input  logic [N_CH-1:0]           ch_enable,
    input  logic                      realign,
    output logic                      ready,
    output logic                      rst_out,
    output logic [N_CH-1:0]           clk_en
);

    localparam int unsigned CntMax = (STABLE_CYCLES > RST_HOLD) ? STABLE_CYCLES : RST_HOLD;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [1:0] {StWaitLock, StStable, StHold, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        sync_q, sync_d;
    logic              ready_q, ready_d;
    logic              lock_s;
    logic              run_ok;
    logic [ACC_W-1:0]  acc_q [N_CH];
    logic [ACC_W-1:0]  acc_d [N_CH];
    logic [ACC_W:0]    inc_sat [N_CH];
    logic [ACC_W:0]    sum [N_CH];
    logic [N_CH-1:0]   en_q, en_d;

    assign lock_s  = sync_q[1];
    assign sync_d  = {sync_q[0], lock_in};
    // Accumulate only when RUN persists into the next cycle, so a lock loss
    // clears clk_en in the same cycle that ready falls.
    assign run_ok  = (state_q == StRun) && lock_s;
    assign ready   = ready_q;
    assign rst_out = ~ready_q;
    assign clk_en  = en_q;

    // State register, counter, synchroniser, ready flag and accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
            sync_q  <= '0;
            ready_q <= 1'b0;
            en_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            ready_q <= ready_d;
            en_q    <= en_d;
            for (int i = 0; i < N_CH; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    // Next-state and stability/hold counter; a low lock_s restarts from WAIT_LOCK.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!lock_s) begin
            state_d = StWaitLock;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StWaitLock: begin
                    state_d = StStable;
                    cnt_d   = '0;
                end
                StStable: begin
                    if (cnt_q == CntW'(STABLE_CYCLES - 1)) begin
                        state_d = StHold;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StHold: begin
                    if (cnt_q == CntW'(RST_HOLD - 1)) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StRun: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode: ready is registered and follows the state being entered.
    always_comb begin
        ready_d = (state_d == StRun);
    end

    // Per-channel phase accumulators; increments above 2^ACC_W saturate to 2^ACC_W.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            inc_sat[i] = incr[i*(ACC_W+1) +: ACC_W+1];
            if (inc_sat[i][ACC_W]) begin
                inc_sat[i] = {1'b1, {ACC_W{1'b0}}};
            end
            sum[i] = {1'b0, acc_q[i]} + inc_sat[i];
            if (run_ok && ch_enable[i] && !realign) begin
                acc_d[i] = sum[i][ACC_W-1:0];
                en_d[i]  = sum[i][ACC_W];
            end else begin
                acc_d[i] = '0;
                en_d[i]  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pll_clk_en_sequencer.sv
// Bench for pll_clk_en_sequencer: directed sequences plus randomized traffic, all
// checked against a behavioural model built on lock-streak counting and integer phase.
module tb_pll_clk_en_sequencer;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned ACC_W = 8;
    localparam int unsigned SC    = 8;
    localparam int unsigned RH    = 4;
    localparam int unsigned IW    = ACC_W + 1;
    localparam int          FULL  = 1 << ACC_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 lock_in;
    logic [N_CH*IW-1:0]   incr;
    logic [N_CH-1:0]      ch_enable;
    logic                 realign;
    logic                 ready;
    logic                 rst_out;
    logic [N_CH-1:0]      clk_en;

    always #5 clk = ~clk;

    pll_clk_en_sequencer #(
        .N_CH         (N_CH),
        .ACC_W        (ACC_W),
        .STABLE_CYCLES(SC),
        .RST_HOLD     (RH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .lock_in  (lock_in),
        .incr     (incr),
        .ch_enable(ch_enable),
        .realign  (realign),
        .ready    (ready),
        .rst_out  (rst_out),
        .clk_en   (clk_en)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: lock pipeline, streak of consecutive edges seeing lock_s high, phases.
    int            m_s1, m_s2, m_streak;
    int            m_acc [N_CH];
    logic          m_ready;
    logic [N_CH-1:0] m_en;
    int            edge_no;
    int            strobes [N_CH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_incr(input int ch);
        int v;
        v = int'(incr[ch*IW +: IW]);
        return (v > FULL) ? FULL : v;
    endfunction

    task automatic model_edge();
        int ls;
        int t;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_streak = 0;
            m_ready = 1'b0; m_en = '0;
            for (int ch = 0; ch < N_CH; ch++) m_acc[ch] = 0;
        end else begin
            ls = m_s2;
            m_s2 = m_s1;
            m_s1 = int'(lock_in);
            if (ls != 0) m_streak = (m_streak < 100000) ? m_streak + 1 : m_streak;
            else m_streak = 0;
            // One edge leaves WAIT_LOCK, SC edges in STABLE, RH in HOLD.
            m_ready = (m_streak >= int'(SC + RH + 1));
            for (int ch = 0; ch < N_CH; ch++) begin
                if (m_streak >= int'(SC + RH + 2) && ch_enable[ch] && !realign) begin
                    t = m_acc[ch] + sat_incr(ch);
                    m_en[ch]  = (t >= FULL);
                    m_acc[ch] = t % FULL;
                end else begin
                    m_en[ch]  = 1'b0;
                    m_acc[ch] = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        edge_no++;
        @(negedge clk);
        check_eq("ready", 32'(ready), 32'(m_ready));
        check_eq("rst_out", 32'(rst_out), 32'(!m_ready));
        check_eq("clk_en", 32'(clk_en), 32'(m_en));
        for (int ch = 0; ch < N_CH; ch++) if (clk_en[ch]) strobes[ch]++;
    endtask

    task automatic set_incr(input int ch, input int v);
        incr[ch*IW +: IW] = IW'(v);
    endtask

    task automatic clear_strobes();
        for (int ch = 0; ch < N_CH; ch++) strobes[ch] = 0;
    endtask

    // Runs up to max_cyc cycles and returns the first cycle number with ready high.
    task automatic wait_ready(input int max_cyc, input bit glitch6, output int first);
        first = -1;
        edge_no = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (glitch6) lock_in = (edge_no == 6) ? 1'b0 : 1'b1;
            cycle();
            if (ready && first < 0) first = edge_no;
        end
    endtask

    int first;
    int wait_n;

    initial begin
        rst = 1'b1; lock_in = 1'b0; realign = 1'b0; ch_enable = '0; incr = '0;
        edge_no = 0;
        clear_strobes();
        @(negedge clk);
        cycle();
        cycle();
        check_eq("reset_ready", 32'(ready), 32'd0);
        check_eq("reset_rst_out", 32'(rst_out), 32'd1);
        check_eq("reset_clk_en", 32'(clk_en), 32'd0);

        // Lock-up from cycle 0.
        rst = 1'b0; lock_in = 1'b1;
        wait_ready(20, 1'b0, first);
        check_eq("lockup_cycle", 32'(first), 32'd15);

        // One-cycle lock glitch at cycle 6 during STABLE.
        rst = 1'b1; cycle(); rst = 1'b0;
        wait_ready(30, 1'b1, first);
        check_eq("glitch_cycle", 32'(first), 32'd22);

        // Divide ratios over 256 accumulates.
        set_incr(0, 128); set_incr(1, 256); set_incr(2, 85); set_incr(3, 0);
        ch_enable = 4'hF;
        clear_strobes();
        repeat (256) cycle();
        check_eq("div_ch0", 32'(strobes[0]), 32'd128);
        check_eq("div_ch1", 32'(strobes[1]), 32'd256);
        check_eq("div_ch2", 32'(strobes[2]), 32'd85);
        check_eq("div_ch3", 32'(strobes[3]), 32'd0);

        // Realign two out-of-phase channels, then gate ch1.
        ch_enable = '0; cycle();
        set_incr(0, 64); set_incr(1, 64); set_incr(2, 0);
        ch_enable = 4'b0001; repeat (2) cycle();
        ch_enable = 4'b0011; repeat (3) cycle();
        realign = 1'b1; cycle(); realign = 1'b0;
        repeat (4) cycle();
        check_eq("realign_sync", 32'(clk_en[1:0]), 32'd3);
        ch_enable = 4'b0001; cycle();
        check_eq("gate_off", 32'(clk_en[1]), 32'd0);
        repeat (3) cycle();
        ch_enable = 4'b0011;
        wait_n = -1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (clk_en[1] && wait_n < 0) wait_n = i;
        end
        check_eq("reenable_first", 32'(wait_n), 32'd4);

        // Lock loss in RUN at cycle k=0 of a fresh count.
        set_incr(0, 256); set_incr(1, 256);
        lock_in = 1'b0;
        repeat (2) cycle();
        check_eq("loss_k2_ready", 32'(ready), 32'd1);
        cycle();
        check_eq("loss_k3_ready", 32'(ready), 32'd0);
        check_eq("loss_k3_clk_en", 32'(clk_en), 32'd0);
        lock_in = 1'b1;
        wait_ready(20, 1'b0, first);
        check_eq("relock_cycle", 32'(first), 32'd15);

        // Reset mid-RUN with lock still high.
        rst = 1'b1; cycle(); rst = 1'b0;
        check_eq("midrst_ready", 32'(ready), 32'd0);
        check_eq("midrst_clk_en", 32'(clk_en), 32'd0);
        wait_ready(20, 1'b0, first);
        check_eq("midrst_relock", 32'(first), 32'd15);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                for (int ch = 0; ch < N_CH; ch++) begin
                    case ($urandom_range(0, 5))
                        0: set_incr(ch, 0);
                        1: set_incr(ch, FULL);
                        2: set_incr(ch, int'($urandom_range(FULL + 1, 2 * FULL - 1)));
                        default: set_incr(ch, int'($urandom_range(1, FULL - 1)));
                    endcase
                end
            end
            if ($urandom_range(0, 19) == 0) ch_enable = N_CH'($urandom);
            realign = ($urandom_range(0, 31) == 0);
            if (lock_in) begin
                if ($urandom_range(0, 149) == 0) lock_in = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                lock_in = 1'b1;
            end
            rst = ($urandom_range(0, 499) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
